// File: rtl/data_stack.sv
// Parameter stack for the Forth-style core: registered T/N feed the ULA and Y bus,
// deeper cells live in a small register file, with depth tracking and sticky error flags.
module data_stack #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] T,
  output logic [DATA_WIDTH-1:0] N,
  output logic [PTR_WIDTH-1:0]  depth,
  output logic                  empty,
  output logic                  full,
  output logic                  ovf,
  output logic                  unf
);

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_PUSH    = 3'b001,
    OP_DROP    = 3'b010,
    OP_REPLACE = 3'b011,
    OP_BINOP   = 3'b100,
    OP_SWAP    = 3'b101,
    OP_DUP     = 3'b110,
    OP_NOP2    = 3'b111
  } op_e;

  localparam int MEM_DEPTH = DEPTH - 2;
  localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] ONE_P   = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] TWO_P   = PTR_WIDTH'(2);
  localparam logic [PTR_WIDTH-1:0] THREE_P = PTR_WIDTH'(3);

  logic [DATA_WIDTH-1:0] t_q, t_d, n_q, n_d;
  logic [PTR_WIDTH-1:0]  depth_q, depth_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  ovf_set, unf_set;
  logic                  mem_we;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  has1, has2, has3, at_full;
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  assign has1    = (depth_q != '0);
  assign has2    = (depth_q >= TWO_P);
  assign has3    = (depth_q >= THREE_P);
  assign at_full = (depth_q == DEPTH_P);
  assign wr_idx  = IDX_W'(depth_q - TWO_P);
  assign rd_idx  = IDX_W'(depth_q - THREE_P);
  // The third element becomes the new N on any pop; below depth 3 there is none.
  assign rd_data = has3 ? mem_q[rd_idx] : '0;

  always_comb begin
    t_d     = t_q;
    n_d     = n_q;
    depth_d = depth_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    mem_we  = 1'b0;
    case (op_e'(op))
      OP_PUSH: begin
        if (at_full) ovf_set = 1'b1;
        else begin
          t_d     = din;
          n_d     = t_q;
          mem_we  = has2;
          depth_d = depth_q + ONE_P;
        end
      end
      OP_DUP: begin
        if (!has1)        unf_set = 1'b1;
        else if (at_full) ovf_set = 1'b1;
        else begin
          t_d     = t_q;
          n_d     = t_q;
          mem_we  = has2;
          depth_d = depth_q + ONE_P;
        end
      end
      OP_DROP: begin
        if (!has1) unf_set = 1'b1;
        else begin
          // Invalid N is held at 0, so T correctly clears when depth goes 1->0.
          t_d     = n_q;
          n_d     = rd_data;
          depth_d = depth_q - ONE_P;
        end
      end
      OP_BINOP: begin
        if (!has2) unf_set = 1'b1;
        else begin
          t_d     = din;
          n_d     = rd_data;
          depth_d = depth_q - ONE_P;
        end
      end
      OP_REPLACE: begin
        if (!has1) unf_set = 1'b1;
        else       t_d = din;
      end
      OP_SWAP: begin
        if (!has2) unf_set = 1'b1;
        else begin
          t_d = n_q;
          n_d = t_q;
        end
      end
      default: ;
    endcase
    // A new error in the same cycle as clr_err leaves the flag set.
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    unf_d = unf_set | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q     <= '0;
      n_q     <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      n_q     <= n_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Register-file contents are don't-care after reset; depth gates every read.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[wr_idx] <= n_q;
  end

  assign T     = t_q;
  assign N     = n_q;
  assign depth = depth_q;
  assign empty = (depth_q == '0);
  assign full  = at_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed scoreboard bench for data_stack: the driver queues hand-computed
// expectations, a monitor pops one per cycle after the edge and compares.
module tb_data_stack;
  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, DROP = 3'b010, REPL = 3'b011,
                         BINOP = 3'b100, SWAP = 3'b101, DUP = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op = NOP;
  logic [15:0] din = '0;
  logic        clr_err = 1'b0;
  logic [15:0] T, N;
  logic [4:0]  depth;
  logic        empty, full, ovf, unf;

  typedef struct {
    string       nm;
    logic [15:0] t, n;
    logic [4:0]  d;
    logic        e, f, o, u;
  } exp_t;

  exp_t exp_q[$];
  exp_t ex;
  int   checks = 0;
  int   errors = 0;

  data_stack #(.DATA_WIDTH(16), .DEPTH(16), .PTR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .op(op), .din(din), .clr_err(clr_err),
    .T(T), .N(N), .depth(depth), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exv);
    end
  endtask

  // Monitor: one expectation per issued cycle, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      chk(ex.nm, "T", {16'h0, T}, {16'h0, ex.t});
      chk(ex.nm, "N", {16'h0, N}, {16'h0, ex.n});
      chk(ex.nm, "depth", {27'h0, depth}, {27'h0, ex.d});
      chk(ex.nm, "empty", {31'h0, empty}, {31'h0, ex.e});
      chk(ex.nm, "full", {31'h0, full}, {31'h0, ex.f});
      chk(ex.nm, "ovf", {31'h0, ovf}, {31'h0, ex.o});
      chk(ex.nm, "unf", {31'h0, unf}, {31'h0, ex.u});
    end
  end

  task automatic step(input string nm, input logic r, input logic [2:0] o, input logic [15:0] di,
                      input logic ce, input logic [15:0] et, input logic [15:0] en,
                      input logic [4:0] ed, input logic eo, input logic eu);
    exp_t x;
    @(negedge clk);
    rst = r; op = o; din = di; clr_err = ce;
    x.nm = nm; x.t = et; x.n = en; x.d = ed;
    x.e = (ed == 5'd0); x.f = (ed == 5'd16); x.o = eo; x.u = eu;
    exp_q.push_back(x);
  endtask

  initial begin
    step("reset", 1, NOP, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    // Basic push / binop / drop
    step("push11", 0, PUSH, 16'h0011, 0, 16'h0011, 16'h0000, 1, 0, 0);
    step("push22", 0, PUSH, 16'h0022, 0, 16'h0022, 16'h0011, 2, 0, 0);
    step("push33", 0, PUSH, 16'h0033, 0, 16'h0033, 16'h0022, 3, 0, 0);
    step("binop55", 0, BINOP, 16'h0055, 0, 16'h0055, 16'h0011, 2, 0, 0);
    step("drop_a", 0, DROP, 16'h0, 0, 16'h0011, 16'h0000, 1, 0, 0);
    step("drop_b", 0, DROP, 16'h0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    // Fill to capacity
    for (int i = 1; i <= 16; i++)
      step($sformatf("fill%0d", i), 0, PUSH, 16'(i), 0, 16'(i), 16'(i - 1), 5'(i), 0, 0);
    step("push_full", 0, PUSH, 16'hBEEF, 0, 16'd16, 16'd15, 16, 1, 0);
    step("dup_full", 0, DUP, 16'h0, 0, 16'd16, 16'd15, 16, 1, 0);
    // Drain; N is d-1 while at least two entries remain
    for (int k = 1; k <= 16; k++)
      step($sformatf("drain%0d", k), 0, DROP, 16'h0, 0, 16'(16 - k),
           (16 - k >= 2) ? 16'(15 - k) : 16'h0, 5'(16 - k), 1, 0);
    step("clr_ovf", 0, NOP, 16'h0, 1, 16'h0, 16'h0, 0, 0, 0);
    // Underflow cases at depth 0
    step("drop_empty", 0, DROP, 16'h0, 0, 16'h0, 16'h0, 0, 0, 1);
    step("clr_unf", 0, NOP, 16'h0, 1, 16'h0, 16'h0, 0, 0, 0);
    step("repl_empty", 0, REPL, 16'h0007, 0, 16'h0, 16'h0, 0, 0, 1);
    step("clr_unf2", 0, NOP, 16'h0, 1, 16'h0, 16'h0, 0, 0, 0);
    step("swap_empty", 0, SWAP, 16'h0, 0, 16'h0, 16'h0, 0, 0, 1);
    step("dup_empty", 0, DUP, 16'h0, 0, 16'h0, 16'h0, 0, 0, 1);
    step("clr_unf3", 0, NOP, 16'h0, 1, 16'h0, 16'h0, 0, 0, 0);
    // depth-1 binop underflow, then swap/dup/replace and readback from the register file
    step("pushB", 0, PUSH, 16'h000B, 0, 16'h000B, 16'h0, 1, 0, 0);
    step("binop_d1", 0, BINOP, 16'h0099, 0, 16'h000B, 16'h0, 1, 0, 1);
    step("clr_unf4", 0, NOP, 16'h0, 1, 16'h000B, 16'h0, 1, 0, 0);
    step("pushA", 0, PUSH, 16'h000A, 0, 16'h000A, 16'h000B, 2, 0, 0);
    step("swap", 0, SWAP, 16'h0, 0, 16'h000B, 16'h000A, 2, 0, 0);
    step("dup", 0, DUP, 16'h0, 0, 16'h000B, 16'h000B, 3, 0, 0);
    step("replace", 0, REPL, 16'hFFFF, 0, 16'hFFFF, 16'h000B, 3, 0, 0);
    step("drop_c", 0, DROP, 16'h0, 0, 16'h000B, 16'h000A, 2, 0, 0);
    step("drop_d", 0, DROP, 16'h0, 0, 16'h000A, 16'h0, 1, 0, 0);
    // Reset mid-sequence wins over a PUSH
    step("push1", 0, PUSH, 16'h0001, 0, 16'h0001, 16'h000A, 2, 0, 0);
    step("push2", 0, PUSH, 16'h0002, 0, 16'h0002, 16'h0001, 3, 0, 0);
    step("push3", 0, PUSH, 16'h0003, 0, 16'h0003, 16'h0002, 4, 0, 0);
    step("rst_push", 1, PUSH, 16'h0077, 0, 16'h0, 16'h0, 0, 0, 0);
    step("post_rst_push", 0, PUSH, 16'h0044, 0, 16'h0044, 16'h0, 1, 0, 0);
    step("drop_e", 0, DROP, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    // Set wins over clear
    step("unf_set", 0, DROP, 16'h0, 0, 16'h0, 16'h0, 0, 0, 1);
    step("clr_and_err", 0, SWAP, 16'h0, 1, 16'h0, 16'h0, 0, 0, 1);
    step("rst_flags", 1, DROP, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; op = NOP; clr_err = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_stack.md
Name: data_stack

Overview:
- Parameter-stack unit for the Forth-style core.
- Holds the top-of-stack register T and the second element N that feed the ULA's T operand and the Y bus.
- Writes the ULA Result back as the new top.
- T and N are registers; deeper entries sit in an internal register file. Depth tracking with sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 16, width of every stack cell.
- DEPTH, 16, total capacity including T and N (minimum 3).
- PTR_WIDTH, 5, width of the depth counter (must hold 0..DEPTH).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  3  stack operation for this cycle: 000 NOP, 001 PUSH, 010 DROP, 011 REPLACE, 100 BINOP, 101 SWAP, 110 DUP, 111 NOP.
- din  input  DATA_WIDTH  write data, normally ULA Result.
- clr_err  input  1  clears the sticky error flags.
- T  output  DATA_WIDTH  top of stack (registered).
- N  output  DATA_WIDTH  second element (registered).
- depth  output  PTR_WIDTH  current number of valid entries.
- empty  output  1  depth==0.
- full  output  1  depth==DEPTH.
- ovf  output  1  sticky overflow error.
- unf  output  1  sticky underflow error.

Behaviour:
- Reset (rst=1 at edge): T=0, N=0, depth=0, ovf=0, unf=0, empty=1, full=0. Register-file contents don't care. Reset wins over any op and over clr_err.
- Entry model (d = depth):
  - T valid iff d>=1; N valid iff d>=2.
  - mem[0..d-3] holds deeper entries; mem[d-3] is the third element.
  - Invalid T/N always read 0.
- One op per cycle; result visible on T/N/depth right after the edge (latency 1). No handshake; op is sampled every cycle.
- Combinational path T,N -> ULA -> din must settle within the cycle. The stack adds no combinational path from inputs to outputs.
- Operations:
  - PUSH: needs d<DEPTH. T<=din; N<=T; if d>=2, mem[d-2]<=N; d+1.
  - DUP: same as PUSH, with din replaced by current T. Needs d>=1 and d<DEPTH.
  - DROP: needs d>=1. T<=N; N<=mem[d-3] if d>=3 else 0; d-1.
  - BINOP: needs d>=2. T<=din; N<=mem[d-3] if d>=3 else 0; d-1. This is the path for two-operand ULA ops (T op N consumes N).
  - REPLACE: needs d>=1. T<=din; depth unchanged. Used for unary ULA ops.
  - SWAP: needs d>=2. T<=N, N<=T.
  - NOP / 111: no change.
- Error conditions:
  - Unmet requirement -> the op is suppressed entirely (no state change except flags).
  - PUSH, or DUP at d==DEPTH -> ovf<=1.
  - DROP, REPLACE or DUP at d==0 -> unf<=1.
  - BINOP or SWAP at d<2 -> unf<=1.
- Flags:
  - ovf/unf stay set until clr_err=1 or rst.
  - clr_err together with a new error in the same cycle -> the flag ends set (set wins).
- Status: empty/full derived from the registered depth.
- Reset mid-sequence: all in-flight state discarded; the first op after reset sees d=0.

Test Plan:
- Reset, then PUSH 0x0011, 0x0022, 0x0033 -> T=0x0033, N=0x0022, depth=3, empty=0.
- From that state, BINOP with din=0x0055 (ADD result) -> T=0x0055, N=0x0011, depth=2. Then DROP -> T=0x0011, N=0, depth=1.
- Fill: PUSH 1..16 -> full=1, T=16, N=15. PUSH 0xBEEF -> state unchanged, ovf=1. Then DROP 16 times yields T sequence 15,14,...,1,0 with depth reaching 0 and empty=1.
- Empty stack: DROP -> unf=1, depth=0, T=0. clr_err -> unf=0. Then REPLACE and SWAP at depth 0 -> unf=1 each time, no state change.
- depth=2 with T=0xA, N=0xB: SWAP -> T=0xB, N=0xA. DUP -> T=0xB, N=0xB, depth=3. REPLACE din=0xFFFF -> T=0xFFFF, depth=3.
- Push 3 values, assert rst together with op=PUSH -> depth=0, T=0, N=0. clr_err and a new error in the same cycle -> flag remains 1.
